// File: rtl/stopwatch_lap_if.sv
// Lap-write request channel between the stopwatch (master) and the SRAM write sink (slave).
// Signal names keep the direction prefix as seen from the stopwatch.
interface stopwatch_lap_if;
  logic        oWR_VALID;
  logic [15:0] oWR_ADDR;
  logic [31:0] oWR_DATA;
  logic        iWR_READY;

  modport master (output oWR_VALID, output oWR_ADDR, output oWR_DATA, input iWR_READY);
  modport slave  (input oWR_VALID, input oWR_ADDR, input oWR_DATA, output iWR_READY);
endinterface

// File: rtl/stopwatch_lap.sv
// BCD mm:ss:cc stopwatch with cumulative/split lap capture.
// Captured laps queue in a small FIFO that drains to SRAM over a valid/ready channel.
module stopwatch_lap #(
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned LAP_DEPTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] BASE_ADDR  = 16'h0000
) (
  input  logic            iPCLK,
  input  logic            iRESET,
  input  logic            iSTART,
  input  logic            iSTOP,
  input  logic            iCLEAR,
  input  logic            iLAP,
  input  logic            iLAP_MODE,
  output logic [23:0]     oTIME,
  output logic [1:0]      oSTATE,
  output logic            oOVF,
  output logic [4:0]      oLAP_COUNT,
  output logic            oLAP_FULL,
  output logic            oLAP_DROP,
  stopwatch_lap_if.master wr
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } lap_req_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [23:0]      r_time;
  logic [23:0]      r_split;
  logic             r_ovf;
  logic [4:0]       r_lap_cnt;
  logic             r_drop;

  lap_req_t         r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_fifo_cnt;

  logic             w_div_wrap, w_tick, w_wrap59;
  logic             w_lap_full, w_lap_take, w_fifo_full, w_pop, w_push, w_lost;
  logic [23:0]      w_time_nxt, w_split_nxt, w_lap_val;
  lap_req_t         w_entry;

  // Ripple BCD increment: digits are cc lo/hi, ss lo/hi, mm lo/hi (ss/mm tens stop at 5).
  function automatic logic [23:0] bcd_next(input logic [23:0] t);
    logic [23:0] res;
    logic        c;
    logic [3:0]  lim;
    res = t;
    c   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (c) begin
        if (t[4*i +: 4] == lim) begin
          res[4*i +: 4] = 4'd0;
        end else begin
          res[4*i +: 4] = t[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return res;
  endfunction

  assign w_div_wrap  = (r_div == DIV_W'(TICK_DIV - 1));
  assign w_tick      = (r_state == S_RUN) && !iCLEAR && w_div_wrap;
  assign w_wrap59    = (r_time == 24'h595999);
  assign w_time_nxt  = bcd_next(r_time);
  assign w_split_nxt = bcd_next(r_split);

  assign w_lap_full  = (r_lap_cnt == 5'(LAP_DEPTH));
  assign w_lap_take  = iLAP && !iCLEAR && (r_state != S_IDLE) && !w_lap_full;
  assign w_fifo_full = (r_fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign w_pop       = (r_fifo_cnt != '0) && wr.iWR_READY;
  // A full FIFO still takes a lap when the head leaves on the same edge.
  assign w_push      = w_lap_take && (!w_fifo_full || w_pop);
  assign w_lost      = w_lap_take && !w_push;

  assign w_lap_val    = iLAP_MODE ? r_split : r_time;
  assign w_entry.addr = BASE_ADDR + {9'd0, r_lap_cnt, 2'b00};
  assign w_entry.data = {r_ovf, iLAP_MODE, 2'b00, r_lap_cnt[3:0], w_lap_val};

  always_ff @(posedge iPCLK or posedge iRESET) begin
    if (iRESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // iCLEAR outranks iSTOP, which outranks iSTART; clearing a running watch keeps it running.
  always_comb begin
    w_state_nxt = r_state;
    if (iCLEAR) begin
      if (r_state != S_RUN) w_state_nxt = S_IDLE;
    end else if (iSTOP) begin
      if (r_state == S_RUN) w_state_nxt = S_PAUSE;
    end else if (iSTART) begin
      if (r_state != S_RUN) w_state_nxt = S_RUN;
    end
  end

  always_ff @(posedge iPCLK or posedge iRESET) begin
    if (iRESET) begin
      r_div     <= '0;
      r_time    <= '0;
      r_split   <= '0;
      r_ovf     <= 1'b0;
      r_lap_cnt <= '0;
      r_drop    <= 1'b0;
    end else begin
      r_drop <= w_lost;
      if (iCLEAR) begin
        r_div     <= '0;
        r_time    <= '0;
        r_split   <= '0;
        r_ovf     <= 1'b0;
        r_lap_cnt <= '0;
      end else begin
        if (r_state == S_RUN) r_div <= w_div_wrap ? '0 : r_div + DIV_W'(1);
        if (w_tick) begin
          r_time <= w_time_nxt;
          if (w_wrap59) r_ovf <= 1'b1;
        end
        // A lap restarts the split from zero even if a tick lands on the same edge.
        if (w_lap_take)  r_split <= '0;
        else if (w_tick) r_split <= w_split_nxt;
        if (w_push) r_lap_cnt <= r_lap_cnt + 5'd1;
      end
    end
  end

  // Lap FIFO is deliberately not touched by iCLEAR: pending writes keep their captured contents.
  always_ff @(posedge iPCLK or posedge iRESET) begin
    if (iRESET) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_entry;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
      else if (w_pop && !w_push) r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
    end
  end

  assign oTIME         = r_time;
  assign oSTATE        = r_state;
  assign oOVF          = r_ovf;
  assign oLAP_COUNT    = r_lap_cnt;
  assign oLAP_FULL     = w_lap_full;
  assign oLAP_DROP     = r_drop;
  assign wr.oWR_VALID  = (r_fifo_cnt != '0);
  assign wr.oWR_ADDR   = r_fifo[r_rd_ptr].addr;
  assign wr.oWR_DATA   = r_fifo[r_rd_ptr].data;

endmodule

// File: doc/stopwatch_lap.md
STOPWATCH_LAP -- requirements
Module: stopwatch_lap

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000: iPCLK cycles per 10 ms tick, minimum 2.
REQ-002 SHALL have parameter LAP_DEPTH, default 16: maximum laps per session, power of 2, 2..16.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: pending lap-write entries, power of 2, 2..8.
REQ-004 SHALL have parameter BASE_ADDR, default 16'h0000: SRAM byte address of lap 0.
REQ-005 SHALL have iPCLK  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have iRESET  input  1  asynchronous, active-high reset.
REQ-007 SHALL have iSTART  input  1  start/resume request, level sampled each cycle.
REQ-008 SHALL have iSTOP  input  1  pause request.
REQ-009 SHALL have iCLEAR  input  1  clear time, split and lap index.
REQ-010 SHALL have iLAP  input  1  lap capture request, one capture per high cycle.
REQ-011 SHALL have iLAP_MODE  input  1  0 = cumulative lap, 1 = split lap.
REQ-012 SHALL have oTIME  output  24  BCD mm:ss:cc, [23:16] min, [15:8] sec, [7:0] centisec.
REQ-013 SHALL have oSTATE  output  2  00 IDLE, 01 RUN, 10 PAUSE.
REQ-014 SHALL have oOVF  output  1  sticky wrap flag, set when 59:59.99 rolls over.
REQ-015 SHALL have oLAP_COUNT  output  5  laps accepted since the last clear.
REQ-016 SHALL have oLAP_FULL  output  1  high while oLAP_COUNT == LAP_DEPTH.
REQ-017 SHALL have oLAP_DROP  output  1  one-cycle pulse when a lap is lost because the FIFO is full.
REQ-018 SHALL have oWR_VALID  output  1  a lap-write request is pending.
REQ-019 SHALL have oWR_ADDR  output  16  lap-write byte address.
REQ-020 SHALL have oWR_DATA  output  32  lap-write data.
REQ-021 SHALL have iWR_READY  input  1  the sink accepts the write on a rising edge where oWR_VALID is high.

Function
REQ-022 SHALL implement FSM IDLE/RUN/PAUSE: IDLE+iSTART->RUN; RUN+iSTOP->PAUSE; PAUSE+iSTART->RUN; iCLEAR in IDLE/PAUSE->IDLE.
REQ-023 SHALL apply priority iCLEAR > iSTOP > iSTART; iCLEAR in RUN zeroes time, split and index and stays in RUN.
REQ-024 SHALL run the tick divider 0..TICK_DIV-1 only in RUN, hold it in PAUSE and zero it on iCLEAR.
REQ-025 SHALL increment oTIME and the split counter by one centisecond on the edge where the divider wraps.
REQ-026 SHALL carry in BCD: cc 99->00 into ss, ss 59->00 into mm, mm 59->00 sets oOVF; oOVF clears only on iCLEAR or reset.
REQ-027 SHALL ignore iLAP in IDLE and while oLAP_FULL is high; neither case raises oLAP_DROP.
REQ-028 SHALL capture a lap as the pre-increment oTIME (mode 0) or the pre-increment split (mode 1) of the sampling cycle.
REQ-029 SHALL reload the split counter to 000000 on every accepted lap; a tick on that same edge is not added to split.
REQ-030 SHALL format oWR_DATA as [23:0] time, [27:24] lap index, [29:28] 0, [30] iLAP_MODE, [31] oOVF, all at capture.
REQ-031 SHALL set oWR_ADDR = BASE_ADDR + 4*index, fixed at capture; index = oLAP_COUNT before increment.
REQ-032 SHALL, with a free FIFO slot, push the entry and increment oLAP_COUNT; with the FIFO full, drop the lap, pulse oLAP_DROP and hold oLAP_COUNT.
REQ-033 SHALL raise oWR_VALID the cycle after capture into an empty FIFO; writes leave in capture order.
REQ-034 SHALL hold oWR_ADDR/oWR_DATA stable while oWR_VALID is high and iWR_READY is low; pop on the accepting edge.
REQ-035 SHALL accept a push and a pop on the same edge when the FIFO is full.
REQ-036 SHALL not flush the FIFO on iCLEAR; pending writes keep their captured address and data.

Reset
REQ-037 SHALL, on iRESET, go to IDLE, zero the divider, oTIME, split, oOVF, oLAP_COUNT, oLAP_FULL, oLAP_DROP and oWR_VALID, and empty the FIFO.
REQ-038 SHALL drop any pending write on reset mid-transfer; oWR_VALID goes low asynchronously.

Verification (TICK_DIV=4, LAP_DEPTH=4, FIFO_DEPTH=2)
REQ-039 SHALL test: iSTART for 1 cycle, run 400 cycles -> oTIME=24'h000100, oSTATE=01; iSTOP -> oTIME frozen, oSTATE=10.
REQ-040 SHALL test: run 360000 ticks -> oTIME=24'h000000, oOVF=1; iCLEAR -> oOVF=0.
REQ-041 SHALL test: iWR_READY=0 and 3 laps -> 3rd lap pulses oLAP_DROP, oLAP_COUNT=2; iWR_READY=1 -> writes to 0x0000 then 0x0004.
REQ-042 SHALL test: iLAP_MODE=1, laps at 00.25 and 00.75 -> oWR_DATA[23:0]=000025 then 000050.
REQ-043 SHALL test: 4 laps accepted -> oLAP_FULL=1, a 5th lap is ignored with no oLAP_DROP; iSTART with iSTOP in IDLE -> stays IDLE.
REQ-044 SHALL test: iRESET during RUN with oWR_VALID=1 -> all outputs 0 and IDLE immediately.
